// File: rtl/req_manager_mc_if.sv
// Bundle of request, RX, TX and row-buffer handshake signals around the request manager.
// The master modport is the manager itself; slave is whatever surrounds it.
interface req_manager_mc_if #(
    parameter int DATA_WIDTH   = 512,
    parameter int REQ_ID_WIDTH = 32,
    parameter int NUM_RX       = 2
);
    logic [REQ_ID_WIDTH-1:0]      REQ_ID_IN;
    logic                         REQ_ID_VALID;
    logic                         READY_FOR_REQ;
    logic [NUM_RX*DATA_WIDTH-1:0] AXIS_RX_TDATA;
    logic [NUM_RX-1:0]            AXIS_RX_TVALID;
    logic [NUM_RX-1:0]            AXIS_RX_TREADY;
    logic [DATA_WIDTH-1:0]        AXIS_TX_TDATA;
    logic                         AXIS_TX_TVALID;
    logic                         AXIS_TX_TLAST;
    logic                         AXIS_TX_TREADY;
    logic [DATA_WIDTH-1:0]        AXIS_RBF_TDATA;
    logic                         AXIS_RBF_TVALID;
    logic                         AXIS_RBF_TREADY;
    logic [3:0]                   CHANNEL_SEL;
    logic [31:0]                  PACKET_COUNT;

    modport master (
        input  REQ_ID_IN, REQ_ID_VALID, AXIS_RX_TDATA, AXIS_RX_TVALID,
               AXIS_TX_TREADY, AXIS_RBF_TREADY,
        output READY_FOR_REQ, AXIS_RX_TREADY, AXIS_TX_TDATA, AXIS_TX_TVALID,
               AXIS_TX_TLAST, AXIS_RBF_TDATA, AXIS_RBF_TVALID, CHANNEL_SEL, PACKET_COUNT
    );

    modport slave (
        output REQ_ID_IN, REQ_ID_VALID, AXIS_RX_TDATA, AXIS_RX_TVALID,
               AXIS_TX_TREADY, AXIS_RBF_TREADY,
        input  READY_FOR_REQ, AXIS_RX_TREADY, AXIS_TX_TDATA, AXIS_TX_TVALID,
               AXIS_TX_TLAST, AXIS_RBF_TDATA, AXIS_RBF_TVALID, CHANNEL_SEL, PACKET_COUNT
    );
endinterface

// File: rtl/req_manager_mc.sv
// Turns queued row-request IDs into framed TX packets (header, data beats, footer),
// rotating the RX source per packet and mirroring selected channels into the row buffer.
module req_manager_mc #(
    parameter int DATA_WIDTH       = 512,
    parameter int REQ_ID_WIDTH     = 32,
    parameter int NUM_RX           = 2,
    parameter int BEATS_PER_PACKET = 16,
    parameter int RBF_MASK         = 1
) (
    input logic              clk,
    input logic              reset,
    req_manager_mc_if.master bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_FOOTER = 2'd3;

    localparam logic [15:0] RBF_SEL = 16'(RBF_MASK);
    localparam logic [7:0]  BEATS   = 8'(BEATS_PER_PACKET);
    localparam logic [3:0]  LAST_CH = 4'(NUM_RX - 1);

    logic [1:0]              state;
    logic                    req_full;
    logic [REQ_ID_WIDTH-1:0] req_id;
    logic [REQ_ID_WIDTH-1:0] pkt_id;
    logic [7:0]              beats_left;
    logic [3:0]              channel_sel;
    logic [31:0]             packet_count;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_valid;
    logic                    tx_last;
    logic [DATA_WIDTH-1:0]   rbf_data;
    logic                    rbf_valid;

    logic                  tx_fire;
    logic                  tx_free;
    logic                  rbf_free;
    logic                  rx_ready;
    logic                  rx_fire;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic [NUM_RX-1:0]     rx_tready;
    logic                  mirror;
    logic                  req_consume;
    logic                  req_capture;
    logic                  ready_for_req;

    always_comb begin
        rx_data  = '0;
        rx_valid = 1'b0;
        for (int i = 0; i < NUM_RX; i++) begin
            if (channel_sel == 4'(i)) begin
                rx_data  = bus.AXIS_RX_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                rx_valid = bus.AXIS_RX_TVALID[i];
            end
        end
    end

    assign tx_fire  = tx_valid && bus.AXIS_TX_TREADY;
    assign tx_free  = !tx_valid || bus.AXIS_TX_TREADY;
    assign rbf_free = !rbf_valid || bus.AXIS_RBF_TREADY;

    // In HEADER tx_free equals the header handshake, so the first data beat can follow it directly.
    assign rx_ready = !reset && (state == ST_HEADER || state == ST_DATA) &&
                      (beats_left != 8'd0) && tx_free && rbf_free;
    assign rx_fire  = rx_ready && rx_valid;
    assign mirror   = RBF_SEL[channel_sel];

    always_comb begin
        rx_tready = '0;
        for (int i = 0; i < NUM_RX; i++) begin
            rx_tready[i] = rx_ready && (channel_sel == 4'(i));
        end
    end

    assign req_consume   = req_full && ((state == ST_IDLE) || (state == ST_FOOTER && tx_fire));
    assign ready_for_req = !reset && (!req_full || req_consume);
    assign req_capture   = bus.REQ_ID_VALID && ready_for_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_full <= 1'b0;
            req_id   <= '0;
        end else if (req_capture) begin
            req_full <= 1'b1;
            req_id   <= bus.REQ_ID_IN;
        end else if (req_consume) begin
            req_full <= 1'b0;
        end
    end

    // Packet framing; a data intake later in the block overrides whatever the case arm loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            tx_last      <= 1'b0;
            pkt_id       <= '0;
            beats_left   <= '0;
            channel_sel  <= '0;
            packet_count <= '0;
        end else begin
            if (tx_fire) begin
                tx_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (req_full) begin
                        tx_data    <= DATA_WIDTH'(req_id);
                        tx_valid   <= 1'b1;
                        tx_last    <= 1'b0;
                        pkt_id     <= req_id;
                        beats_left <= BEATS;
                        state      <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (tx_fire) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beats_left == 8'd0 && tx_free) begin
                        tx_data  <= DATA_WIDTH'(pkt_id);
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b1;
                        state    <= ST_FOOTER;
                    end
                end
                ST_FOOTER: begin
                    if (tx_fire) begin
                        packet_count <= packet_count + 32'd1;
                        channel_sel  <= (channel_sel == LAST_CH) ? 4'd0 : channel_sel + 4'd1;
                        tx_last      <= 1'b0;
                        if (req_full) begin
                            tx_data    <= DATA_WIDTH'(req_id);
                            tx_valid   <= 1'b1;
                            pkt_id     <= req_id;
                            beats_left <= BEATS;
                            state      <= ST_HEADER;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (rx_fire) begin
                tx_data    <= rx_data;
                tx_valid   <= 1'b1;
                tx_last    <= 1'b0;
                beats_left <= beats_left - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rbf_data  <= '0;
            rbf_valid <= 1'b0;
        end else begin
            if (rbf_valid && bus.AXIS_RBF_TREADY) begin
                rbf_valid <= 1'b0;
            end
            if (rx_fire && mirror) begin
                rbf_data  <= rx_data;
                rbf_valid <= 1'b1;
            end
        end
    end

    assign bus.READY_FOR_REQ   = ready_for_req;
    assign bus.AXIS_RX_TREADY  = rx_tready;
    assign bus.AXIS_TX_TDATA   = tx_data;
    assign bus.AXIS_TX_TVALID  = tx_valid;
    assign bus.AXIS_TX_TLAST   = tx_last;
    assign bus.AXIS_RBF_TDATA  = rbf_data;
    assign bus.AXIS_RBF_TVALID = rbf_valid;
    assign bus.CHANNEL_SEL     = channel_sel;
    assign bus.PACKET_COUNT    = packet_count;
endmodule

// File: tb/tb_req_manager_mc.sv
// Randomised bench: a packet-level model predicts every TX and RBF beat from the accepted
// request order, channel rotation and per-channel payload sequence numbers.
module tb_req_manager_mc;
    localparam int DW    = 32;
    localparam int IW    = 16;
    localparam int NRX   = 3;
    localparam int BEATS = 16;
    localparam int MASK  = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    req_manager_mc_if #(.DATA_WIDTH(DW), .REQ_ID_WIDTH(IW), .NUM_RX(NRX)) bus ();

    req_manager_mc #(
        .DATA_WIDTH(DW), .REQ_ID_WIDTH(IW), .NUM_RX(NRX),
        .BEATS_PER_PACKET(BEATS), .RBF_MASK(MASK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         tx_exp[$];
    logic [DW-1:0] rbf_exp[$];
    logic [IW-1:0] id_q[$];
    int            req_cyc[$];
    int            foot_cyc[$];
    bit            ready_log[int];
    int            src_ptr[NRX];
    int            nexp[NRX];
    int pkt_idx, footers, cyc, errors, checks;
    int tx_hs_count, rbf_hs_count, run_len, max_run, last_tx_cyc, first_valid_cyc, rbf_stall_cycles;
    int tx_mode, rbf_mode, rx_mode, req_mode;
    bit prev_reset;
    logic tx_toggle;

    function automatic logic [DW-1:0] payload(input int ch, input int n);
        return {8'(ch), 24'(n)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus();
        bus.REQ_ID_VALID = (id_q.size() != 0) && (req_mode == 0 || $urandom_range(0, 1) == 1);
        bus.REQ_ID_IN    = (id_q.size() != 0) ? id_q[0] : '0;
        tx_toggle = ~tx_toggle;
        case (tx_mode)
            0:       bus.AXIS_TX_TREADY = 1'b1;
            1:       bus.AXIS_TX_TREADY = tx_toggle;
            default: bus.AXIS_TX_TREADY = ($urandom_range(0, 3) != 0);
        endcase
        case (rbf_mode)
            0:       bus.AXIS_RBF_TREADY = 1'b1;
            1:       bus.AXIS_RBF_TREADY = ($urandom_range(0, 2) != 0);
            default: bus.AXIS_RBF_TREADY = 1'b0;
        endcase
        for (int c = 0; c < NRX; c++) begin
            bus.AXIS_RX_TVALID[c]          = (rx_mode == 0) || ($urandom_range(0, 2) != 0);
            bus.AXIS_RX_TDATA[c*DW +: DW]  = payload(c, src_ptr[c]);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            applyStimulus();
        end
    endtask

    task automatic waitDrain(input int limit);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            @(negedge clk);
            applyStimulus();
            n++;
            #3;
            done = (id_q.size() == 0) && (tx_exp.size() == 0) && (rbf_exp.size() == 0) &&
                   !bus.AXIS_TX_TVALID && !bus.AXIS_RBF_TVALID;
        end
        checkOutput("drain within budget", done, 1);
        run_cycles(2);
    endtask

    task automatic clear_trackers();
        tx_hs_count = 0; rbf_hs_count = 0; run_len = 0; max_run = 0;
        last_tx_cyc = -10; first_valid_cyc = -1; rbf_stall_cycles = 0;
        req_cyc.delete(); foot_cyc.delete();
    endtask

    // Monitor: samples between edges, checks against the model, then advances it on handshakes.
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (reset) begin
            checkOutput("reset ready_for_req", bus.READY_FOR_REQ, 0);
            checkOutput("reset rx_tready", bus.AXIS_RX_TREADY, 0);
            tx_exp.delete();
            rbf_exp.delete();
            pkt_idx = 0;
            footers = 0;
            for (int c = 0; c < NRX; c++) begin
                src_ptr[c] = 0;
                nexp[c]    = 0;
            end
            prev_reset = 1'b1;
        end else begin
            int exp_ch;
            if (prev_reset) begin
                checkOutput("post-reset tx_tvalid", bus.AXIS_TX_TVALID, 0);
                checkOutput("post-reset tx_tlast", bus.AXIS_TX_TLAST, 0);
                checkOutput("post-reset tx_tdata", bus.AXIS_TX_TDATA, 0);
                checkOutput("post-reset rbf_tvalid", bus.AXIS_RBF_TVALID, 0);
                checkOutput("post-reset ready_for_req", bus.READY_FOR_REQ, 1);
            end
            prev_reset = 1'b0;
            ready_log[cyc] = bus.READY_FOR_REQ;
            exp_ch = footers % NRX;
            checkOutput("channel_sel", bus.CHANNEL_SEL, exp_ch);
            checkOutput("packet_count", bus.PACKET_COUNT, footers);
            checkOutput("rx_tready off-channel", bus.AXIS_RX_TREADY & ~(NRX'(1) << exp_ch), 0);
            if (bus.AXIS_RBF_TVALID && !bus.AXIS_RBF_TREADY) begin
                rbf_stall_cycles++;
                checkOutput("rx_tready during rbf stall", bus.AXIS_RX_TREADY, 0);
            end
            if (bus.AXIS_TX_TVALID) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (tx_exp.size() == 0) begin
                    checkOutput("tx unexpected beat", tx_exp.size(), 1);
                end else begin
                    checkOutput("tx_tdata", bus.AXIS_TX_TDATA, tx_exp[0].data);
                    checkOutput("tx_tlast", bus.AXIS_TX_TLAST, tx_exp[0].last);
                end
                if (bus.AXIS_TX_TREADY) begin
                    if (tx_exp.size() != 0) begin
                        if (tx_exp[0].last) begin
                            footers++;
                            foot_cyc.push_back(cyc);
                        end
                        void'(tx_exp.pop_front());
                    end
                    tx_hs_count++;
                    run_len = (last_tx_cyc == cyc - 1) ? run_len + 1 : 1;
                    last_tx_cyc = cyc;
                    if (run_len > max_run) max_run = run_len;
                end
            end else begin
                checkOutput("tx_tlast while idle", bus.AXIS_TX_TLAST, 0);
            end
            if (bus.AXIS_RBF_TVALID) begin
                if (rbf_exp.size() == 0) begin
                    checkOutput("rbf unexpected beat", rbf_exp.size(), 1);
                end else begin
                    checkOutput("rbf_tdata", bus.AXIS_RBF_TDATA, rbf_exp[0]);
                end
                if (bus.AXIS_RBF_TREADY) begin
                    if (rbf_exp.size() != 0) void'(rbf_exp.pop_front());
                    rbf_hs_count++;
                end
            end
            for (int c = 0; c < NRX; c++) begin
                if (bus.AXIS_RX_TVALID[c] && bus.AXIS_RX_TREADY[c]) src_ptr[c]++;
            end
            if (bus.REQ_ID_VALID && bus.READY_FOR_REQ && id_q.size() != 0) begin
                logic [IW-1:0] id;
                int ch;
                id = id_q.pop_front();
                req_cyc.push_back(cyc);
                ch = pkt_idx % NRX;
                pkt_idx++;
                tx_exp.push_back('{data: DW'(id), last: 1'b0});
                for (int k = 0; k < BEATS; k++) begin
                    tx_exp.push_back('{data: payload(ch, nexp[ch] + k), last: 1'b0});
                    if (((MASK >> ch) & 1) == 1) rbf_exp.push_back(payload(ch, nexp[ch] + k));
                end
                nexp[ch] += BEATS;
                tx_exp.push_back('{data: DW'(id), last: 1'b1});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, n;
        errors = 0; checks = 0; cyc = 0; pkt_idx = 0; footers = 0;
        prev_reset = 1'b0; tx_toggle = 1'b0;
        tx_mode = 0; rbf_mode = 0; rx_mode = 0; req_mode = 0;
        for (int c = 0; c < NRX; c++) begin
            src_ptr[c] = 0;
            nexp[c]    = 0;
        end
        clear_trackers();
        applyStimulus();

        reset = 1'b1;
        run_cycles(3);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus();

        // Back-to-back packets with a third request held off until the first footer.
        clear_trackers();
        id_q.push_back(16'hA1);
        id_q.push_back(16'hA2);
        id_q.push_back(16'hA3);
        waitDrain(400);
        checkOutput("phase2 accepted requests", req_cyc.size(), 3);
        if (req_cyc.size() >= 3 && foot_cyc.size() >= 1) begin
            checkOutput("header latency", first_valid_cyc - req_cyc[0], 2);
            checkOutput("3rd request at first footer", req_cyc[2], foot_cyc[0]);
            checkOutput("ready low while one held", ready_log[req_cyc[1] + 1], 0);
        end
        checkOutput("back-to-back tx run", max_run, 3 * (BEATS + 2));
        checkOutput("phase2 rbf beats", rbf_hs_count, BEATS);
        checkOutput("phase2 packet_count", bus.PACKET_COUNT, 3);
        checkOutput("phase2 channel_sel wrap", bus.CHANNEL_SEL, 0);

        // TX ready toggling every cycle.
        clear_trackers();
        tx_mode = 1;
        id_q.push_back(16'hB1);
        id_q.push_back(16'hB2);
        id_q.push_back(16'hB3);
        waitDrain(800);
        checkOutput("toggle tx beats", tx_hs_count, 3 * (BEATS + 2));
        checkOutput("toggle no consecutive hs", max_run, 1);
        tx_mode = 0;

        // Row-buffer stall of 20 cycles in the middle of a ch0 packet.
        clear_trackers();
        base = src_ptr[0];
        id_q.push_back(16'hC1);
        n = 0;
        while (src_ptr[0] < base + 6 && n < 100) begin
            run_cycles(1);
            n++;
        end
        checkOutput("phase4 reached mid-packet", src_ptr[0] >= base + 6, 1);
        rbf_mode = 2;
        rbf_stall_cycles = 0;
        run_cycles(20);
        checkOutput("rbf stall held", rbf_stall_cycles >= 19, 1);
        rbf_mode = 0;
        waitDrain(400);
        checkOutput("phase4 rbf beats", rbf_hs_count, BEATS);
        checkOutput("phase4 ch0 beats", src_ptr[0] - base, BEATS);

        // Fully random traffic.
        clear_trackers();
        tx_mode = 2; rbf_mode = 1; rx_mode = 1; req_mode = 1;
        for (int i = 0; i < 25; i++) id_q.push_back(IW'($urandom));
        waitDrain(12000);
        checkOutput("random tx beats", tx_hs_count, 25 * (BEATS + 2));
        checkOutput("random packet_count", bus.PACKET_COUNT, 32);
        tx_mode = 0; rbf_mode = 0; rx_mode = 0; req_mode = 0;

        // Reset in the middle of a packet, then a clean packet from ch0.
        @(negedge clk);
        reset = 1'b1;
        applyStimulus();
        run_cycles(1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus();
        id_q.push_back(16'hD1);
        n = 0;
        while (src_ptr[0] < 7 && n < 100) begin
            run_cycles(1);
            n++;
        end
        checkOutput("phase6 reached beat 7", src_ptr[0], 7);
        @(negedge clk);
        reset = 1'b1;
        id_q.delete();
        applyStimulus();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus();
        clear_trackers();
        id_q.push_back(16'hD2);
        waitDrain(400);
        checkOutput("post-reset packet beats", tx_hs_count, BEATS + 2);
        checkOutput("post-reset rbf beats", rbf_hs_count, BEATS);
        checkOutput("post-reset packet_count", bus.PACKET_COUNT, 1);
        checkOutput("post-reset channel_sel", bus.CHANNEL_SEL, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
